lane_scroll_ctrl: RTL
=====================

LANE_SCROLL_CTRL -- requirements
Module: lane_scroll_ctrl

Interface
REQ-001 Parameter: NUM_LINES, 6, number of dashed line segments driven.
REQ-002 Parameter: LINE_LEN, 64, visible segment length in rows.
REQ-003 Parameter: LINE_PITCH, 104, row spacing between segment starts; virtual track length TRACK_LEN = NUM_LINES*LINE_PITCH = 624.
REQ-004 Parameter: ACCEL_FRAMES, 8, frame ticks per 1 px/frame step of actual speed.
REQ-005 Parameter: C1_START/C1_END/C2_START/C2_END, 211/214/425/428, lane-divider column bounds.
REQ-006 Port: clk  in  1  pixel clock; the block's one clock.
REQ-007 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-008 Port: pix_row, pix_col  in  10 each  current display-timing pixel location.
REQ-009 Port: run  in  1  level; 1 = scroll, 0 = hold.
REQ-010 Port: clear  in  1  single-cycle pulse; return to IDLE, offset 0.
REQ-011 Port: target_speed  in  3  requested scroll speed, px/frame.
REQ-012 Port: lineN_r_start, lineN_r_end (N=1..6)  out  10 each  row bounds of segment N.
REQ-013 Port: line_c1_start/end, line_c2_start/end  out  10 each  column bounds (parameter values).
REQ-014 Port: speed_act  out  3  current applied speed.
REQ-015 Port: distance  out  16  accumulated scrolled rows, saturating.
REQ-016 Port: frame_tick  out  1  one-cycle pulse per frame.

Function
REQ-017 frame_tick: 1 for exactly one cycle on the first clk with pix_row==480 after a clk with pix_row!=480; registered, so it asserts the cycle after detection.
REQ-018 FSM states: IDLE, RUN, HOLD; all updates to offset/speed_act/distance occur only on frame_tick cycles.
REQ-019 IDLE: offset=0, speed_act=0, distance=0; run=1 -> RUN.
REQ-020 RUN: on tick, offset <= (offset+speed_act) mod 624 (single conditional subtract of 624); distance += speed_act; run=0 -> HOLD.
REQ-021 HOLD: offset, distance frozen; speed_act forced to 0; run=1 -> RUN.
REQ-022 clear=1 -> IDLE from any state, takes priority over run and over a coincident tick.
REQ-023 Speed ramp in RUN: frame counter counts ticks; every ACCEL_FRAMES ticks speed_act steps by 1 toward target_speed (up or down); equal -> no change; counter resets on reaching ACCEL_FRAMES and on leaving RUN.
REQ-024 On a tick where offset and speed_act both update, offset uses pre-update speed_act.
REQ-025 distance saturates at 16'hFFFF; no wrap.
REQ-026 Segment position: s_i = (offset + (i-1)*LINE_PITCH) mod 624, e_i = s_i + LINE_LEN - 1.
REQ-027 If e_i > 623 (wrapping segment): output start 0, end e_i - 624.
REQ-028 Else if s_i <= 479: output start s_i, end min(e_i, 479).
REQ-029 Else (fully off-screen): output start 1023, end 1023.
REQ-030 Segment outputs registered; valid the cycle after the offset update, stable for the rest of the frame.
REQ-031 Column outputs equal their parameters continuously after reset.

Reset
REQ-032 reset_n low asynchronously forces IDLE, offset 0, speed_act 0, distance 0, frame_tick 0, ramp counter 0.
REQ-033 Segment outputs after reset: (0,63),(104,167),(208,271),(312,375),(416,479),(1023,1023); column outputs 211/214/425/428.
REQ-034 Reset asserted mid-frame or mid-ramp discards all progress; first tick after release updates nothing unless run=1 and state is RUN.

Verification
REQ-035 Reset release, run=0, 3 frames -> outputs stay at REQ-033 values, frame_tick pulses once per frame (pix_row 479->480).
REQ-036 ACCEL_FRAMES=1, target_speed=4, run=1 -> after ticks 1..5 offset 0,1,3,6,10; speed_act 1,2,3,4,4; distance 10.
REQ-037 Force offset 620 -> segment1 (0,59), segment5 (412,475), segment6 (1023,1023); next tick at speed 4 -> offset 0.
REQ-038 Running at speed 4, run dropped -> HOLD, offset frozen, speed_act 0; run re-raised -> ramp restarts from 0.
REQ-039 clear coincident with frame_tick and run=1 -> IDLE, offset 0, distance 0 next cycle.
REQ-040 distance preloaded 65533, speed 7, one tick -> distance 65535, stays there on further ticks.

Source files
------------

// File: rtl/lane_scroll_ctrl.sv
// Scrolling lane-marker controller: per-frame offset/speed/distance update and registered segment row bounds.
// Latency: state moves on the frame_tick cycle, segment bounds one cycle later; no backpressure (free-running).
module lane_scroll_ctrl #(
  parameter int NUM_LINES    = 6,
  parameter int LINE_LEN     = 64,
  parameter int LINE_PITCH   = 104,
  parameter int ACCEL_FRAMES = 8,
  parameter int C1_START     = 211,
  parameter int C1_END       = 214,
  parameter int C2_START     = 425,
  parameter int C2_END       = 428
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pix_row,
  input  logic [9:0]  pix_col,
  input  logic        run,
  input  logic        clear,
  input  logic [2:0]  target_speed,
  output logic [9:0]  line1_r_start,
  output logic [9:0]  line1_r_end,
  output logic [9:0]  line2_r_start,
  output logic [9:0]  line2_r_end,
  output logic [9:0]  line3_r_start,
  output logic [9:0]  line3_r_end,
  output logic [9:0]  line4_r_start,
  output logic [9:0]  line4_r_end,
  output logic [9:0]  line5_r_start,
  output logic [9:0]  line5_r_end,
  output logic [9:0]  line6_r_start,
  output logic [9:0]  line6_r_end,
  output logic [9:0]  line_c1_start,
  output logic [9:0]  line_c1_end,
  output logic [9:0]  line_c2_start,
  output logic [9:0]  line_c2_end,
  output logic [2:0]  speed_act,
  output logic [15:0] distance,
  output logic        frame_tick
);

  localparam int TRACK_LEN = NUM_LINES * LINE_PITCH;
  localparam int VIS_ROWS  = 480;
  localparam int CW        = $clog2(ACCEL_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t        state_q, state_d;
  logic [9:0]    offset_q, offset_d;
  logic [2:0]    speed_q, speed_d;
  logic [15:0]   dist_q, dist_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          row480_q, tick_q, tick_d;
  logic [9:0]    off_sum, off_wrap;
  logic [16:0]   dist_sum;
  logic [15:0]   dist_sat;
  logic [9:0]    seg_s_q [NUM_LINES];
  logic [9:0]    seg_e_q [NUM_LINES];
  logic [9:0]    seg_s_d [NUM_LINES];
  logic [9:0]    seg_e_d [NUM_LINES];
  logic          unused_pix_col;

  assign unused_pix_col = ^pix_col;

  // Start/end rows of segment idx for a given track offset; 1023 marks a fully hidden segment.
  function automatic logic [19:0] seg_calc(input logic [9:0] off, input int idx);
    logic [10:0] s;
    logic [10:0] e;
    s = 11'(off) + 11'(idx * LINE_PITCH);
    if (s >= 11'(TRACK_LEN)) s = s - 11'(TRACK_LEN);
    e = s + 11'(LINE_LEN - 1);
    if (e > 11'(TRACK_LEN - 1))
      return {10'd0, 10'(e - 11'(TRACK_LEN))};
    else if (s < 11'(VIS_ROWS))
      return {s[9:0], (e > 11'(VIS_ROWS - 1)) ? 10'(VIS_ROWS - 1) : e[9:0]};
    else
      return {10'd1023, 10'd1023};
  endfunction

  assign tick_d   = (pix_row == 10'(VIS_ROWS)) && !row480_q;
  assign off_sum  = offset_q + 10'(speed_q);
  assign off_wrap = (off_sum >= 10'(TRACK_LEN)) ? off_sum - 10'(TRACK_LEN) : off_sum;
  assign dist_sum = {1'b0, dist_q} + {14'd0, speed_q};
  assign dist_sat = dist_sum[16] ? 16'hFFFF : dist_sum[15:0];
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    speed_d  = speed_q;
    dist_d   = dist_q;
    cnt_d    = cnt_q;
    if (clear) begin
      state_d  = IDLE;
      offset_d = '0;
      speed_d  = '0;
      dist_d   = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: if (run) state_d = RUN;
        RUN: begin
          if (!run) begin
            state_d = HOLD;
            speed_d = '0;
            cnt_d   = '0;
          end else if (tick_q) begin
            // Offset and distance advance by the speed held before this tick's ramp step.
            offset_d = off_wrap;
            dist_d   = dist_sat;
            if (cnt_inc == CW'(ACCEL_FRAMES)) begin
              cnt_d = '0;
              if (speed_q < target_speed)      speed_d = speed_q + 3'd1;
              else if (speed_q > target_speed) speed_d = speed_q - 3'd1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        HOLD: begin
          speed_d = '0;
          cnt_d   = '0;
          if (run) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
      {seg_s_d[i], seg_e_d[i]} = seg_calc(offset_q, i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      offset_q <= '0;
      speed_q  <= '0;
      dist_q   <= '0;
      cnt_q    <= '0;
      row480_q <= 1'b0;
      tick_q   <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
        {seg_s_q[i], seg_e_q[i]} <= seg_calc(10'd0, i);
      end
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      speed_q  <= speed_d;
      dist_q   <= dist_d;
      cnt_q    <= cnt_d;
      row480_q <= (pix_row == 10'(VIS_ROWS));
      tick_q   <= tick_d;
      for (int i = 0; i < NUM_LINES; i++) begin
        seg_s_q[i] <= seg_s_d[i];
        seg_e_q[i] <= seg_e_d[i];
      end
    end
  end

  assign line1_r_start = seg_s_q[0];
  assign line1_r_end   = seg_e_q[0];
  assign line2_r_start = seg_s_q[1];
  assign line2_r_end   = seg_e_q[1];
  assign line3_r_start = seg_s_q[2];
  assign line3_r_end   = seg_e_q[2];
  assign line4_r_start = seg_s_q[3];
  assign line4_r_end   = seg_e_q[3];
  assign line5_r_start = seg_s_q[4];
  assign line5_r_end   = seg_e_q[4];
  assign line6_r_start = seg_s_q[5];
  assign line6_r_end   = seg_e_q[5];

  assign line_c1_start = 10'(C1_START);
  assign line_c1_end   = 10'(C1_END);
  assign line_c2_start = 10'(C2_START);
  assign line_c2_end   = 10'(C2_END);

  assign speed_act  = speed_q;
  assign distance   = dist_q;
  assign frame_tick = tick_q;

endmodule
